// File: rtl/nn_out_collector.sv
// Pairs the two skewed column result lanes into rows, queues them, and
// serialises each row as two 16-bit words on a valid/ready stream.
module nn_out_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     col1_valid,
  input  logic [15:0]              col1_data,
  input  logic                     col2_valid,
  input  logic [15:0]              col2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CW-1:0]            rows_done,
  output logic                     err_overflow,
  output logic                     err_orphan
);

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  typedef struct packed {
    logic [DW-1:0] lane1;
    logic [DW-1:0] lane2;
  } row_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT1 = 2'd1,
    S_EMIT2 = 2'd2
  } state_t;

  // Pairing hold register
  logic [DW-1:0] h1, h1_nxt;
  logic          h1_v, h1_v_nxt;
  logic          push_c, orphan_c;
  row_t          push_row_c;

  // FIFO storage and bookkeeping
  row_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full_c, empty_c, push_ok_c;
  row_t          head_c;

  // Serialiser
  state_t        state, state_nxt;
  logic          pop_c, row_done_c;
  logic [DW-1:0] lane2_q, lane2_nxt;
  logic          out_valid_nxt, out_last_nxt;
  logic [DW-1:0] out_data_nxt;

  assign full_c    = (fifo_count == CNTW'(DEPTH));
  assign empty_c   = (fifo_count == '0);
  assign head_c    = mem[rd_ptr];
  // A push into a full FIFO survives only if the serialiser frees a slot this cycle
  assign push_ok_c = push_c && (!full_c || pop_c);

  // Pairing rules: col2 completes a row with whatever lane-1 value is waiting
  always_comb begin
    h1_nxt     = h1;
    h1_v_nxt   = h1_v;
    push_c     = 1'b0;
    orphan_c   = 1'b0;
    push_row_c = '0;
    if (col1_valid && col2_valid) begin
      push_c = 1'b1;
      if (h1_v) begin
        push_row_c = {h1, col2_data};
        h1_nxt     = col1_data;
      end else begin
        push_row_c = {col1_data, col2_data};
      end
    end else if (col1_valid) begin
      orphan_c = h1_v;
      h1_nxt   = col1_data;
      h1_v_nxt = 1'b1;
    end else if (col2_valid) begin
      if (h1_v) begin
        push_c     = 1'b1;
        push_row_c = {h1, col2_data};
        h1_v_nxt   = 1'b0;
      end else begin
        orphan_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1           <= '0;
      h1_v         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
      rows_done    <= '0;
    end else if (clear) begin
      h1           <= '0;
      h1_v         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
      rows_done    <= '0;
    end else begin
      h1   <= h1_nxt;
      h1_v <= h1_v_nxt;
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push_c && !push_ok_c) err_overflow <= 1'b1;
      if (orphan_c)             err_orphan   <= 1'b1;
      if (row_done_c)           rows_done    <= rows_done + CW'(1);
    end
  end

  // Storage needs no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push_ok_c && !clear) mem[wr_ptr] <= push_row_c;
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= S_IDLE;
    else if (clear) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Serialiser next state; EMIT2 chains straight into the next row when one is queued
  always_comb begin
    state_nxt  = state;
    pop_c      = 1'b0;
    row_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c     = 1'b1;
          state_nxt = S_EMIT1;
        end
      end
      S_EMIT1: begin
        if (out_ready) state_nxt = S_EMIT2;
      end
      S_EMIT2: begin
        if (out_ready) begin
          row_done_c = 1'b1;
          if (!empty_c) begin
            pop_c     = 1'b1;
            state_nxt = S_EMIT1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Serialiser output words, registered below
  always_comb begin
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    lane2_nxt     = lane2_q;
    if (pop_c) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = head_c.lane1;
      out_last_nxt  = 1'b0;
      lane2_nxt     = head_c.lane2;
    end else if (state == S_EMIT1 && out_ready) begin
      out_data_nxt = lane2_q;
      out_last_nxt = 1'b1;
    end else if (state == S_EMIT2 && out_ready) begin
      out_valid_nxt = 1'b0;
      out_data_nxt  = '0;
      out_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      lane2_q   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      lane2_q   <= '0;
    end else begin
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      lane2_q   <= lane2_nxt;
    end
  end

endmodule

// File: tb/tb_nn_out_collector.sv
// Directed and randomized checks of nn_out_collector against a queue-based
// cycle model of the pairing, FIFO and two-word serialisation rules.
module tb_nn_out_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 16;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            col1_valid, col2_valid;
  logic [15:0]     col1_data, col2_data;
  logic            out_valid, out_ready, out_last;
  logic [15:0]     out_data;
  logic [CNTW-1:0] fifo_count;
  logic [CW-1:0]   rows_done;
  logic            err_overflow, err_orphan;

  nn_out_collector #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .col1_valid   (col1_valid),
    .col1_data    (col1_data),
    .col2_valid   (col2_valid),
    .col2_data    (col2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .fifo_count   (fifo_count),
    .rows_done    (rows_done),
    .err_overflow (err_overflow),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: rows as {lane1, lane2}
  logic [31:0] m_q[$];
  logic [15:0] m_h1;
  bit          m_h1v;
  bit          m_valid;
  bit          m_phase;
  logic [31:0] m_row;
  logic [15:0] m_rows;
  bit          m_ovf, m_orph;

  // Words seen on the output as {last, data}
  logic [16:0] got[$];
  logic [16:0] exp_w[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_h1 = '0; m_h1v = 0; m_valid = 0; m_phase = 0; m_row = '0;
    m_rows = '0; m_ovf = 0; m_orph = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [31:0] row;
    logic [31:0] head;
    bit push, pop, done;
    row = '0; head = '0; push = 0;
    if (clear) begin
      model_reset();
      return;
    end
    if (col1_valid && col2_valid) begin
      push = 1;
      row  = m_h1v ? {m_h1, col2_data} : {col1_data, col2_data};
      if (m_h1v) m_h1 = col1_data;
    end else if (col1_valid) begin
      if (m_h1v) m_orph = 1;
      m_h1  = col1_data;
      m_h1v = 1;
    end else if (col2_valid) begin
      if (m_h1v) begin
        push  = 1;
        row   = {m_h1, col2_data};
        m_h1v = 0;
      end else begin
        m_orph = 1;
      end
    end
    done = m_valid && m_phase && out_ready;
    pop  = (m_q.size() > 0) && (!m_valid || done);
    if (pop) head = m_q.pop_front();
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(row);
      else m_ovf = 1;
    end
    if (pop) begin
      m_row = head; m_valid = 1; m_phase = 0;
    end else if (m_valid && out_ready) begin
      if (!m_phase) m_phase = 1;
      else m_valid = 0;
    end
    if (done) m_rows = m_rows + 16'd1;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_phase ? m_row[15:0] : m_row[31:16]));
      chk("out_last", 32'(out_last), 32'(m_phase));
    end
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("rows_done", 32'(rows_done), 32'(m_rows));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_orphan", 32'(err_orphan), 32'(m_orph));
  endtask

  task automatic cycle();
    if (out_valid === 1'b1 && out_ready) got.push_back({out_last, out_data});
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    col1_valid = 0; col2_valid = 0; clear = 0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic compare_words(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp_w[i]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_rows"}, 32'(rows_done), 32'd0);
    chk({tag, "_ovf"}, 32'(err_overflow), 32'd0);
    chk({tag, "_orph"}, 32'(err_orphan), 32'd0);
  endtask

  // Drive one row, bring it to its lane-2 word, leave out_ready low
  task automatic to_emit2(input logic [15:0] a, input logic [15:0] b);
    out_ready = 0;
    col1_valid = 1; col1_data = a; col2_valid = 1; col2_data = b;
    cycle();
    idle_inputs();
    wait_valid();
    out_ready = 1;
    cycle();
    out_ready = 0;
    chk("emit2_last", 32'(out_last), 32'd1);
    chk("emit2_data", 32'(out_data), 32'(b));
  endtask

  initial begin
    logic [15:0] d1, d2;
    rst = 0; clear = 0; out_ready = 0;
    col1_valid = 0; col2_valid = 0; col1_data = '0; col2_data = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    rst = 1;
    cycle();

    // Skewed two-row stream
    out_ready = 1; got.delete();
    col1_valid = 1; col1_data = 16'h0100; cycle();
    col1_data = 16'h0200; col2_valid = 1; col2_data = 16'h0300; cycle();
    col1_valid = 0; col2_data = 16'h0400; cycle();
    idle_inputs();
    repeat (8) cycle();
    exp_w = '{17'h00100, 17'h10300, 17'h00200, 17'h10400};
    compare_words("skewed");
    chk("skewed_rows", 32'(rows_done), 32'd2);
    chk("skewed_flags", 32'({err_overflow, err_orphan}), 32'd0);

    // Both lanes together with h1 empty
    got.delete();
    col1_valid = 1; col1_data = 16'hFF80; col2_valid = 1; col2_data = 16'h0040; cycle();
    idle_inputs();
    repeat (6) cycle();
    exp_w = '{17'h0FF80, 17'h10040};
    compare_words("simul");
    chk("simul_flags", 32'({err_overflow, err_orphan}), 32'd0);

    // Backpressure on the first word
    got.delete(); out_ready = 0;
    col1_valid = 1; col1_data = 16'h0100; col2_valid = 1; col2_data = 16'h0200; cycle();
    idle_inputs();
    wait_valid();
    repeat (5) begin
      cycle();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h0100);
    end
    out_ready = 1;
    repeat (6) cycle();
    exp_w = '{17'h00100, 17'h10200};
    compare_words("bp");

    // Overflow: ten rows against a stalled output
    got.delete(); exp_w.delete(); out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      d1 = 16'($urandom); d2 = 16'($urandom);
      col1_valid = 1; col1_data = d1; col2_valid = 1; col2_data = d2;
      if (i < 9) begin
        exp_w.push_back({1'b0, d1});
        exp_w.push_back({1'b1, d2});
      end
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    out_ready = 1;
    repeat (25) cycle();
    compare_words("ovf");
    clear = 1; cycle(); clear = 0;
    chk("clear_ovf", 32'(err_overflow), 32'd0);

    // Orphans, then a correct pairing of the surviving col1
    got.delete();
    col2_valid = 1; col2_data = 16'h1111; cycle();
    col2_valid = 0;
    chk("orph_flag", 32'(err_orphan), 32'd1);
    col1_valid = 1; col1_data = 16'h2222; cycle();
    col1_data = 16'h3333; cycle();
    col1_valid = 0; col2_valid = 1; col2_data = 16'h4444; cycle();
    idle_inputs();
    repeat (6) cycle();
    exp_w = '{17'h03333, 17'h14444};
    compare_words("orph");
    chk("orph_flag_sticky", 32'(err_orphan), 32'd1);

    // Asynchronous reset during the lane-2 word
    to_emit2(16'h5555, 16'h6666);
    #2 rst = 0;
    #1 check_all_zero("rst_mid");
    model_reset();
    rst = 1;
    cycle();

    // Clear during the lane-2 word, after one finished row and an orphan
    col2_valid = 1; col2_data = 16'h7777; cycle(); idle_inputs();
    out_ready = 1;
    col1_valid = 1; col1_data = 16'h1234; col2_valid = 1; col2_data = 16'h5678; cycle();
    idle_inputs();
    repeat (6) cycle();
    chk("pre_clear_rows", 32'(rows_done), 32'd1);
    to_emit2(16'h9ABC, 16'hDEF0);
    clear = 1; cycle(); clear = 0;
    check_all_zero("clear_mid");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      col1_valid = ($urandom_range(0, 1) == 1);
      col2_valid = ($urandom_range(0, 1) == 1);
      col1_data  = 16'($urandom);
      col2_data  = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      clear      = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    out_ready = 1;
    repeat (25) cycle();
    chk("final_drain", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
